// File: rtl/pipearch_common_pkg.sv
// Shared definitions for the FIFO write-path blocks: scheduler state
// encoding, FIFO-region select codes and a small index-width helper.
package pipearch_common;

  // Scheduler lock state: IDLE has no owner, LOCKED holds one requester
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } sched_state_e;

  // Region select driven on wfifobram alongside a write
  localparam logic [1:0] FIFO_REGION_SEL  = 2'b10;
  // Region select driven when no write is issued
  localparam logic [1:0] FIFO_REGION_NONE = 2'b00;

  // Width of an index into n requesters, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_scheduler_rr_arbiter.sv
// Combinational round-robin selector. Priority starts at the requester
// right after last_winner and wraps around the requester ring.
module rr_arbiter
  import pipearch_common::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int IDX_W          = idx_width(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic [IDX_W-1:0]          last_winner,
  output logic [NUM_REQUESTERS-1:0] grant,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      grant_valid
);

  // slot s holds the requester index s+1 positions after the last winner
  logic [IDX_W-1:0]          slot_idx [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0] slot_req;

  generate
    for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_slot
      assign slot_idx[gi] = IDX_W'((int'(last_winner) + gi + 1) % NUM_REQUESTERS);
      assign slot_req[gi] = req[slot_idx[gi]];
    end
  endgenerate

  // Pick the first requesting slot in rotated priority order
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int s = 0; s < NUM_REQUESTERS; s++) begin
      if (!grant_valid && slot_req[s]) begin
        grant_valid = 1'b1;
        grant_idx   = slot_idx[s];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_grant
      assign grant[gi] = grant_valid && (grant_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/fifo_write_scheduler.sv
// Burst-locking write scheduler: arbitrates requesters round-robin, holds
// the grant for a whole burst and forwards each accepted beat to the
// downstream FIFO write port one cycle later.
module fifo_write_scheduler
  import pipearch_common::*;
#(
  parameter int WIDTH          = 8,
  parameter int NUM_REQUESTERS = 4,
  parameter int LOG2_DEPTH     = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQUESTERS-1:0]            req_valid,
  input  logic [NUM_REQUESTERS-1:0][WIDTH-1:0] req_data,
  input  logic [NUM_REQUESTERS-1:0]            req_last,
  output logic [NUM_REQUESTERS-1:0]            req_ready,
  output logic                                 we,
  output logic [1:0]                           wfifobram,
  output logic [WIDTH-1:0]                     wdata,
  input  logic                                 almostfull,
  input  logic [LOG2_DEPTH:0]                  count,
  output logic                                 busy,
  output logic [idx_width(NUM_REQUESTERS)-1:0] grant_id,
  output logic [31:0]                          beats_written
);

  localparam int IDX_W = idx_width(NUM_REQUESTERS);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQUESTERS - 1);

  // occupancy is informational only; almostfull carries the flow control
  logic unused_count;
  assign unused_count = ^count;

  sched_state_e              state_q, state_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic [NUM_REQUESTERS-1:0] grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0]          last_q, last_d;
  logic                      we_q, we_d;
  logic [1:0]                wfifobram_q, wfifobram_d;
  logic [WIDTH-1:0]          wdata_q, wdata_d;
  logic [31:0]               beats_q, beats_d;

  logic [NUM_REQUESTERS-1:0] arb_grant;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_valid;
  logic                      locked;
  logic                      accept;

  rr_arbiter #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .IDX_W          (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .last_winner (last_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign locked = (state_q == ST_LOCKED);

  // only the owner sees ready, and only while downstream has room
  assign req_ready = locked ? (grant_oh_q & {NUM_REQUESTERS{!almostfull}}) : '0;

  assign accept = locked && req_valid[grant_q] && !almostfull;

  // Next-state: arbitrate in IDLE, stream beats and release on last in LOCKED
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    last_d      = last_q;
    we_d        = 1'b0;
    wfifobram_d = FIFO_REGION_NONE;
    wdata_d     = wdata_q;
    beats_d     = beats_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d    = ST_LOCKED;
          grant_d    = arb_idx;
          grant_oh_d = arb_grant;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          we_d        = 1'b1;
          wfifobram_d = FIFO_REGION_SEL;
          wdata_d     = req_data[grant_q];
          beats_d     = beats_q + 32'd1;
          if (req_last[grant_q]) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any burst in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      last_q      <= LAST_INIT;
      we_q        <= 1'b0;
      wfifobram_q <= FIFO_REGION_NONE;
      wdata_q     <= '0;
      beats_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      last_q      <= last_d;
      we_q        <= we_d;
      wfifobram_q <= wfifobram_d;
      wdata_q     <= wdata_d;
      beats_q     <= beats_d;
    end
  end

  assign we            = we_q;
  assign wfifobram     = wfifobram_q;
  assign wdata         = wdata_q;
  assign busy          = locked;
  assign grant_id      = grant_q;
  assign beats_written = beats_q;

endmodule

// File: tb/tb_fifo_write_scheduler.sv
// Directed bench for fifo_write_scheduler: reset, single burst, fairness,
// backpressure, burst lock, reset mid-burst and counter wrap.
module tb_fifo_write_scheduler;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int LD = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          req_valid;
  logic [N-1:0][W-1:0]   req_data;
  logic [N-1:0]          req_last;
  logic [N-1:0]          req_ready;
  logic                  we;
  logic [1:0]            wfifobram;
  logic [W-1:0]          wdata;
  logic                  almostfull;
  logic [LD:0]           count;
  logic                  busy;
  logic [1:0]            grant_id;
  logic [31:0]           beats_written;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_write_scheduler #(
    .WIDTH          (W),
    .NUM_REQUESTERS (N),
    .LOG2_DEPTH     (LD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .we            (we),
    .wfifobram     (wfifobram),
    .wdata         (wdata),
    .almostfull    (almostfull),
    .count         (count),
    .busy          (busy),
    .grant_id      (grant_id),
    .beats_written (beats_written)
  );

  task automatic idle_inputs();
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    almostfull = 1'b0;
    count      = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = 4'b1111;
    req_data   = 32'hDEADBEEF;
    req_last   = 4'b0101;
    almostfull = 1'b0;
    count      = 6'd3;
    @(negedge clk);
    @(negedge clk);
    $display("reset: we=%0b wfb=%b wdata=%02h rdy=%b busy=%0b gid=%0d beats=%0d",
             we, wfifobram, wdata, req_ready, busy, grant_id, beats_written);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", we); end
    total++; if (wfifobram !== 2'b00) begin bad++; $display("FAIL reset_wfifobram got=%b want=00", wfifobram); end
    total++; if (wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h want=00", wdata); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant_id); end
    total++; if (beats_written !== 32'd0) begin bad++; $display("FAIL reset_beats got=%0d want=0", beats_written); end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_burst();
    logic [W-1:0] d [3];
    d = '{8'h11, 8'h22, 8'h33};
    do_reset();
    req_valid[0] = 1'b1;
    req_data[0]  = d[0];
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_arb_ready got=%b want=0000", req_ready); end
    @(negedge clk);
    total++; if (busy !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL single_lock got busy=%b gid=%0d want busy=1 gid=0", busy, grant_id); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL single_lock_we got=%b want=0", we); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    for (int k = 0; k < 3; k++) begin
      req_data[0] = d[k];
      req_last[0] = (k == 2);
      @(negedge clk);
      $display("single beat %0d: we=%0b wfb=%b wdata=%02h busy=%0b", k, we, wfifobram, wdata, busy);
      total++; if (we !== 1'b1 || wfifobram !== 2'b10 || wdata !== d[k]) begin
        bad++; $display("FAIL single_beat%0d got we=%b wfb=%b wdata=%h want we=1 wfb=10 wdata=%h", k, we, wfifobram, wdata, d[k]);
      end
      total++; if (busy !== (k < 2)) begin bad++; $display("FAIL single_busy%0d got=%b want=%b", k, busy, (k < 2)); end
    end
    total++; if (beats_written !== 32'd3) begin bad++; $display("FAIL single_beats got=%0d want=3", beats_written); end
    idle_inputs();
    @(negedge clk);
    total++; if (we !== 1'b0 || wfifobram !== 2'b00 || wdata !== 8'h33) begin
      bad++; $display("FAIL single_after got we=%b wfb=%b wdata=%h want we=0 wfb=00 wdata=33", we, wfifobram, wdata);
    end
  endtask

  task automatic test_fairness();
    int exp_order [5];
    int ng = 0;
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i] = 8'hA0 + W'(i);
    for (int cyc = 0; cyc < 20 && ng < 5; cyc++) begin
      @(negedge clk);
      if (we === 1'b1 && ng > 0) begin
        total++; if (wdata !== 8'hA0 + W'(exp_order[ng-1])) begin
          bad++; $display("FAIL fair_wdata got=%h want=%h", wdata, 8'hA0 + W'(exp_order[ng-1]));
        end
      end
      if (busy === 1'b1) begin
        $display("fairness grant %0d: gid=%0d", ng, grant_id);
        total++; if (grant_id !== 2'(exp_order[ng])) begin
          bad++; $display("FAIL fair_grant%0d got=%0d want=%0d", ng, grant_id, exp_order[ng]);
        end
        ng++;
      end
    end
    total++; if (ng != 5) begin bad++; $display("FAIL fair_timeout got grants=%0d want=5", ng); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] bp [4];
    int idx = 0;
    logic [N-1:0] exp_rdy;
    logic acc;
    bp = '{8'h51, 8'h52, 8'h53, 8'h54};
    do_reset();
    for (int c = 0; c < 12; c++) begin
      almostfull   = (c >= 3 && c <= 7);
      req_valid[2] = (idx < 4);
      req_data[2]  = bp[(idx < 4) ? idx : 3];
      req_last[2]  = (idx == 3);
      #1;
      exp_rdy = (c >= 1 && !almostfull && idx < 4) ? 4'b0100 : 4'b0000;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL bp_ready c=%0d got=%b want=%b", c, req_ready, exp_rdy); end
      acc = exp_rdy[2] && req_valid[2];
      @(negedge clk);
      $display("backpressure c=%0d: af=%0b we=%0b wdata=%02h", c, almostfull, we, wdata);
      total++; if (we !== acc || (acc && wdata !== bp[idx])) begin
        bad++; $display("FAIL bp_write c=%0d got we=%b wdata=%h want we=%b wdata=%h", c, we, wdata, acc, bp[(idx < 4) ? idx : 3]);
      end
      if (acc) idx++;
    end
    total++; if (beats_written !== 32'd4 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_end got beats=%0d busy=%b want beats=4 busy=0", beats_written, busy);
    end
    idle_inputs();
  endtask

  task automatic test_burst_lock();
    logic [N-1:0] exp_rdy;
    logic acc;
    logic [W-1:0] exp_d;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      req_valid[1] = (c <= 1) || (c >= 6 && c <= 7);
      req_data[1]  = (c <= 1) ? 8'h61 : ((c == 6) ? 8'h62 : 8'h63);
      req_last[1]  = (c == 7);
      req_valid[3] = (c >= 1 && c <= 9);
      req_data[3]  = 8'h77;
      req_last[3]  = 1'b1;
      #1;
      exp_rdy = '0;
      exp_rdy[1] = (c >= 1 && c <= 7);
      exp_rdy[3] = (c == 9);
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL lock_ready c=%0d got=%b want=%b", c, req_ready, exp_rdy); end
      acc   = (c >= 1 && c <= 7 && req_valid[1]) || (c == 9);
      exp_d = (c == 9) ? 8'h77 : req_data[1];
      @(negedge clk);
      $display("burst_lock c=%0d: we=%0b wdata=%02h busy=%0b gid=%0d", c, we, wdata, busy, grant_id);
      total++; if (we !== acc || (acc && wdata !== exp_d)) begin
        bad++; $display("FAIL lock_write c=%0d got we=%b wdata=%h want we=%b wdata=%h", c, we, wdata, acc, exp_d);
      end
      if (c == 8) begin
        total++; if (busy !== 1'b1 || grant_id !== 2'd3) begin
          bad++; $display("FAIL lock_next got busy=%b gid=%0d want busy=1 gid=3", busy, grant_id);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    // single beat from req 2 moves the round-robin pointer away from 0
    req_valid[2] = 1'b1; req_last[2] = 1'b1; req_data[2] = 8'h2C;
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    total++; if (we !== 1'b1 || wdata !== 8'h2C) begin bad++; $display("FAIL rmid_pre got we=%b wdata=%h want we=1 wdata=2c", we, wdata); end
    req_valid[0] = 1'b1; req_data[0] = 8'h01;
    @(negedge clk);
    @(negedge clk);
    req_data[0] = 8'h02;
    @(negedge clk);
    total++; if (we !== 1'b1 || wdata !== 8'h02 || beats_written !== 32'd3) begin
      bad++; $display("FAIL rmid_beats got we=%b wdata=%h beats=%0d want we=1 wdata=02 beats=3", we, wdata, beats_written);
    end
    reset = 1'b1;
    @(negedge clk);
    $display("reset_mid: we=%0b busy=%0b beats=%0d", we, busy, beats_written);
    total++; if (we !== 1'b0 || busy !== 1'b0 || beats_written !== 32'd0) begin
      bad++; $display("FAIL rmid_reset got we=%b busy=%b beats=%0d want we=0 busy=0 beats=0", we, busy, beats_written);
    end
    reset = 1'b0;
    req_valid = 4'b1001; req_last = 4'b1001;
    @(negedge clk);
    total++; if (busy !== 1'b1 || grant_id !== 2'd0) begin
      bad++; $display("FAIL rmid_pointer got busy=%b gid=%0d want busy=1 gid=0", busy, grant_id);
    end
    idle_inputs();
  endtask

  task automatic test_counter_wrap();
    do_reset();
    req_valid[1] = 1'b1; req_last[1] = 1'b1; req_data[1] = 8'h99;
    @(negedge clk);
    force dut.beats_q = 32'hFFFF_FFFF;
    #1;
    release dut.beats_q;
    @(negedge clk);
    $display("counter_wrap: we=%0b wdata=%02h beats=%08h", we, wdata, beats_written);
    total++; if (beats_written !== 32'd0 || we !== 1'b1) begin
      bad++; $display("FAIL wrap got beats=%h we=%b want beats=00000000 we=1", beats_written, we);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_fairness();
    test_backpressure();
    test_burst_lock();
    test_reset_mid_burst();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
